// File: rtl/rv32_lsu_if.sv
// rv32_lsu_if: data-memory request/acknowledge bus between the LSU and memory.
interface rv32_lsu_if #(
    parameter int width = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [width-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [width-1:0] mem_wdata;
    logic             mem_ack;
    logic [width-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/rv32_lsu.sv
// rv32_lsu: RV32I load/store unit with lane steering, byte enables, load extension and a req/ack memory handshake.
// Optional macro LSU_TIMEOUT_EN adds an ACCESS watchdog of TIMEOUT_CYCLES cycles that retires the op with op_err.
module rv32_lsu #(
    parameter int width = 32
`ifdef LSU_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic             CLK,
    input  logic             reset_,
    input  logic             op_valid,
    input  logic             op_store,
    input  logic [2:0]       func3,
    input  logic [width-1:0] op_addr,
    input  logic [width-1:0] op_wdata,
    output logic             busy,
    output logic             op_done,
    output logic             op_err,
    output logic [width-1:0] op_rdata,
    rv32_lsu_if.master       mem
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state, state_nx;
    logic             legal, take, err_q, err_nx, tmo;
    logic [3:0]       be_nx;
    logic [width-1:0] wd_nx, ld_val;
    logic [2:0]       ld_f3;
    logic [1:0]       lane;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;

    // Decode legality (funct3 + alignment) and steer store data/enables for the incoming op
    always_comb begin
        legal = (func3[1:0] != 2'b11) && !(func3[2] && (op_store || func3[1])) &&
                (func3[1:0] == 2'b01 ? !op_addr[0] :
                 func3[1:0] == 2'b10 ? op_addr[1:0] == 2'b00 : 1'b1);
        be_nx = func3[1] ? 4'b1111 : func3[0] ? (op_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << op_addr[1:0];
        wd_nx = func3[1] ? op_wdata : func3[0] ? {2{op_wdata[15:0]}} : {4{op_wdata[7:0]}};
        take  = (state == IDLE) && op_valid && legal;
    end

    // Pick the addressed lane of the returned word and sign/zero extend it
    always_comb begin
        ld_b   = 8'(mem.mem_rdata >> {lane, 3'b000});
        ld_h   = lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        ld_val = ld_f3[1] ? mem.mem_rdata :
                 ld_f3[0] ? {{16{~ld_f3[2] & ld_h[15]}}, ld_h} :
                            {{24{~ld_f3[2] & ld_b[7]}}, ld_b};
    end

`ifdef LSU_TIMEOUT_EN
    localparam int cw = $clog2(TIMEOUT_CYCLES + 1);
    logic [cw-1:0] cnt;

    assign tmo = cnt == cw'(TIMEOUT_CYCLES - 1);

    // Count ACCESS cycles; zero outside ACCESS so each access starts from a cleared count
    always_ff @(posedge CLK or negedge reset_) begin
        if (!reset_) cnt <= '0;
        else         cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
    end
`else
    assign tmo = 1'b0;
`endif

    // Next state and error flag; op_valid is only looked at in IDLE
    always_comb begin
        state_nx = state;
        err_nx   = err_q;
        case (state)
            IDLE: if (op_valid) begin
                state_nx = legal ? ACCESS : DONE;
                err_nx   = !legal;
            end
            ACCESS: if (mem.mem_ack) begin
                state_nx = DONE;
                err_nx   = 1'b0;
            end else if (tmo) begin
                state_nx = DONE;
                err_nx   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and error register
    always_ff @(posedge CLK or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
        end
    end

    // Capture the memory command once at acceptance so it stays stable for the whole access
    always_ff @(posedge CLK or negedge reset_) begin
        if (!reset_) begin
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
            ld_f3         <= '0;
            lane          <= '0;
        end else if (take) begin
            mem.mem_we    <= op_store;
            mem.mem_addr  <= {op_addr[width-1:2], 2'b00};
            mem.mem_be    <= be_nx;
            mem.mem_wdata <= wd_nx;
            ld_f3         <= func3;
            lane          <= op_addr[1:0];
        end
    end

    // Load result only changes when a load is acknowledged
    always_ff @(posedge CLK or negedge reset_) begin
        if (!reset_)                                             op_rdata <= '0;
        else if (state == ACCESS && mem.mem_ack && !mem.mem_we) op_rdata <= ld_val;
    end

    assign mem.mem_req = state == ACCESS;
    assign op_done     = state == DONE;
    assign op_err      = op_done && err_q;
    assign busy        = (state == IDLE && op_valid) || state == ACCESS;
endmodule

// File: doc/rv32_lsu.md
Name: rv32_lsu

Overview:
- Load/store unit between the RV32I core's data port and the data memory.
- Accepts one LOAD/STORE operation at a time from the core.
- Handles byte/halfword lane steering, byte enables, and sign/zero extension of load data.
- Runs a req/ack handshake with variable-latency memory and stalls the core until the access retires.

Parameters:
- width, 32, datapath and address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- reset_  input  1  asynchronous active-low reset.
- op_valid  input  1  core presents a load/store this cycle.
- op_store  input  1  1=store, 0=load.
- func3  input  3  RV32I funct3: LB/LH/LW/LBU/LHU or SB/SH/SW.
- op_addr  input  width  effective byte address.
- op_wdata  input  width  store source register value.
- busy  output  1  core must hold PC and instruction while high.
- op_done  output  1  one-cycle pulse: operation retired.
- op_err  output  1  valid with op_done: misaligned address, illegal func3, or timeout.
- op_rdata  output  width  extended load result.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable.
- mem_addr  output  width  word address; op_addr with bits [1:0] forced to 0.
- mem_be  output  4  byte enables.
- mem_wdata  output  width  lane-replicated store data.
- mem_ack  input  1  memory completes the request this cycle.
- mem_rdata  input  width  read word; valid when mem_ack=1 on a load.

Behaviour:
- Reset (async, reset_=0):
  - state=IDLE; all outputs 0, including op_rdata.
  - mem_req falls immediately without waiting for a clock edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If op_valid=0: stay in IDLE.
  - Legality check on op_valid=1:
    - Loads: func3 in {000,001,010,100,101}.
    - Stores: func3 in {000,001,010}.
    - Halfword ops need addr[0]=0; word ops need addr[1:0]=00.
  - op_valid=1 and legal: register mem_addr/mem_we/mem_be/mem_wdata/load-type/addr[1:0]; set mem_req=1; go ACCESS.
  - op_valid=1 and illegal: no memory access; go DONE with op_err=1.
- ACCESS:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_ack is sampled high.
  - On mem_ack: mem_req=0 next cycle; a load updates op_rdata; go DONE with op_err=0.
  - mem_ack in IDLE or DONE is ignored.
- DONE:
  - op_done=1 for exactly one cycle; go IDLE.
  - op_valid is ignored here, because the core still shows the same instruction this cycle.
- busy:
  - busy = (IDLE & op_valid) | ACCESS.
  - busy=0 in DONE, so the core advances at the end of the op_done cycle.
- Latency:
  - op_valid accepted at edge N gives mem_req high in cycle N+1.
  - Zero-wait ack gives op_done in cycle N+2.
  - Illegal operation gives op_done+op_err in cycle N+1.
- mem_be (loads and stores):
  - Byte: 0001 << addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
- mem_wdata:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata unchanged.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- op_rdata:
  - Registered; changes only on a successful load.
  - Holds its value across stores, errors and idle cycles.
- op_err=0 whenever op_done=0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Counter cleared on ACCESS entry, incremented each ACCESS cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: drop mem_req, go DONE with op_err=1, op_rdata unchanged.
  - An ack arriving in the same cycle the limit is reached takes priority: normal completion.
- Not defined: no counter; ACCESS waits indefinitely for mem_ack.

Test Plan:
- SW op_addr=0x100, op_wdata=0xDEADBEEF, ack in first ACCESS cycle -> mem_req at N+1 with addr 0x100, be 1111, we 1, wdata 0xDEADBEEF; op_done at N+2, op_err 0.
- LB op_addr=0x103, mem_rdata=0x80FF0011 -> mem_be 1000, op_rdata 0xFFFFFF80; repeat as LBU -> 0x00000080.
- LH op_addr=0x102, mem_rdata=0x80011234 -> op_rdata 0xFFFF8001; LHU -> 0x00008001; SH op_addr=0x102, op_wdata=0x0000ABCD -> be 1100, wdata 0xABCDABCD.
- LW op_addr=0x101, and separately func3=011 load -> no mem_req; op_done=op_err=1 at N+1; op_rdata keeps its prior value.
- mem_ack delayed 3 cycles -> mem_* outputs constant throughout, busy high every ACCESS cycle, op_done exactly one cycle after ack; op_valid held high in DONE does not start a second access.
- reset_ low mid-ACCESS -> mem_req 0 immediately; after release state IDLE, a stale mem_ack is ignored; with LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> op_done+op_err, mem_req drops after 16 ACCESS cycles.
